// File: rtl/spell_pkg.sv
// rtl/spell_pkg.sv - shared memory type constants and arbiter state encoding
package spell_pkg;

    localparam logic [1:0] MemoryTypeData = 2'd0;
    localparam logic [1:0] MemoryTypeCode = 2'd1;
    localparam logic [1:0] MemoryTypeNone = 2'd3;

    typedef enum logic [1:0] {
        StateIdle    = 2'd0,
        StateBusy    = 2'd1,
        StateRelease = 2'd2
    } arb_state_e;

endpackage

// File: rtl/spell_rr_arbiter2.sv
// rtl/spell_rr_arbiter2.sv - two-way round-robin grant selection
module spell_rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    // A tie goes to whichever port did not win last time.
    always_comb begin
        valid = |req;
        if (&req) begin
            grant = ~last_grant;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/spell_mem_arbiter.sv
// rtl/spell_mem_arbiter.sv - shares one spell memory port between core and host requesters
module spell_mem_arbiter
    import spell_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clock,
    input  logic       reset,

    input  logic       c_select,
    input  logic       c_write,
    input  logic [7:0] c_addr,
    input  logic [7:0] c_data_in,
    input  logic [1:0] c_type,
    output logic [7:0] c_data_out,
    output logic       c_data_ready,
    output logic       c_error,

    input  logic       h_select,
    input  logic       h_write,
    input  logic [7:0] h_addr,
    input  logic [7:0] h_data_in,
    input  logic [1:0] h_type,
    output logic [7:0] h_data_out,
    output logic       h_data_ready,
    output logic       h_error,

    output logic       m_select,
    output logic       m_write,
    output logic [7:0] m_addr,
    output logic [7:0] m_data_in,
    output logic [1:0] m_type,
    input  logic [7:0] m_data_out,
    input  logic       m_data_ready,

    output logic       busy,
    output logic       grant
);

    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

    arb_state_e state, state_next;
    logic       grant_q;
    logic [7:0] timeout_cnt;
    logic [7:0] c_data_q, h_data_q;
    logic       arb_grant, arb_valid;
    logic       in_busy, sel_g, abort, mem_done, timed_out, complete;

    spell_rr_arbiter2 u_rr (
        .req        ({h_select, c_select}),
        .last_grant (grant_q),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    assign in_busy   = (state == StateBusy);
    assign sel_g     = grant_q ? h_select : c_select;
    // A dropped select wins over a same-cycle data_ready so an abort never reports.
    assign abort     = in_busy && !sel_g;
    assign mem_done  = in_busy && sel_g && m_data_ready;
    assign timed_out = in_busy && sel_g && !m_data_ready && (timeout_cnt == TimeoutLimit);
    assign complete  = mem_done || timed_out;

    always_comb begin
        state_next = state;
        unique case (state)
            StateIdle:    if (arb_valid) state_next = StateBusy;
            StateBusy:    if (abort || complete) state_next = StateRelease;
            StateRelease: state_next = StateIdle;
            default:      state_next = StateIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= StateIdle;
            grant_q     <= 1'b1;
            timeout_cnt <= 8'd0;
            c_data_q    <= 8'd0;
            h_data_q    <= 8'd0;
        end else begin
            state <= state_next;
            if (state == StateIdle && arb_valid) begin
                grant_q     <= arb_grant;
                timeout_cnt <= 8'd0;
            end else if (in_busy && timeout_cnt != 8'hFF) begin
                timeout_cnt <= timeout_cnt + 8'd1;
            end
            if (mem_done && !grant_q) c_data_q <= m_data_out;
            if (mem_done &&  grant_q) h_data_q <= m_data_out;
        end
    end

    always_comb begin
        m_select     = in_busy;
        m_write      = in_busy && (grant_q ? h_write : c_write);
        m_addr       = in_busy ? (grant_q ? h_addr    : c_addr)    : 8'd0;
        m_data_in    = in_busy ? (grant_q ? h_data_in : c_data_in) : 8'd0;
        m_type       = in_busy ? (grant_q ? h_type    : c_type)    : MemoryTypeData;
        c_data_ready = complete && !grant_q;
        h_data_ready = complete &&  grant_q;
        c_error      = timed_out && !grant_q;
        h_error      = timed_out &&  grant_q;
    end

    assign c_data_out = c_data_q;
    assign h_data_out = h_data_q;
    assign busy       = (state != StateIdle);
    assign grant      = grant_q;

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// tb/tb_spell_mem_arbiter.sv - self-checking bench for spell_mem_arbiter
module tb_spell_mem_arbiter;
    import spell_pkg::*;

    localparam int TO = 4;

    logic       clock, reset;
    logic       c_select, c_write, h_select, h_write;
    logic [7:0] c_addr, c_data_in, h_addr, h_data_in;
    logic [1:0] c_type, h_type;
    logic [7:0] c_data_out, h_data_out;
    logic       c_data_ready, c_error, h_data_ready, h_error;
    logic       m_select, m_write, m_data_ready;
    logic [7:0] m_addr, m_data_in, m_data_out;
    logic [1:0] m_type;
    logic       busy, grant;

    int         checks, errors;
    bit         model_last;
    logic [7:0] exp_c_out, exp_h_out;

    spell_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .c_select(c_select), .c_write(c_write), .c_addr(c_addr), .c_data_in(c_data_in),
        .c_type(c_type), .c_data_out(c_data_out), .c_data_ready(c_data_ready), .c_error(c_error),
        .h_select(h_select), .h_write(h_write), .h_addr(h_addr), .h_data_in(h_data_in),
        .h_type(h_type), .h_data_out(h_data_out), .h_data_ready(h_data_ready), .h_error(h_error),
        .m_select(m_select), .m_write(m_write), .m_addr(m_addr), .m_data_in(m_data_in),
        .m_type(m_type), .m_data_out(m_data_out), .m_data_ready(m_data_ready),
        .busy(busy), .grant(grant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic no_response(input string tag);
        chk1({tag, "_c_ready"}, c_data_ready, 1'b0);
        chk1({tag, "_h_ready"}, h_data_ready, 1'b0);
        chk1({tag, "_c_error"}, c_error, 1'b0);
        chk1({tag, "_h_error"}, h_error, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        chk1("rst_m_select", m_select, 1'b0);
        chk1("rst_m_write", m_write, 1'b0);
        chk8("rst_m_addr", m_addr, 8'd0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_grant", grant, 1'b1);
        chk8("rst_c_out", c_data_out, 8'd0);
        chk8("rst_h_out", h_data_out, 8'd0);
        no_response("rst");
        reset = 1'b0;
        c_select = 1'b0;
        h_select = 1'b0;
        m_data_ready = 1'b0;
        model_last = 1'b1;
        exp_c_out = 8'd0;
        exp_h_out = 8'd0;
        tick();
    endtask

    // Starts in an Idle cycle; memory answers in Busy cycle 'lat', grantee drops select in cycle 'abort_at'.
    task automatic run_txn(input bit c_req, input bit h_req, input int lat, input int abort_at,
                           input logic [7:0] rdata, input bit keep_c, input bit keep_h);
        bit win, is_to, aborted;
        int done_k;
        win     = (c_req && h_req) ? !model_last : h_req;
        done_k  = (lat < TO + 1) ? lat : TO + 1;
        is_to   = (lat > TO + 1);
        aborted = 1'b0;
        c_select = c_req;
        h_select = h_req;
        m_data_ready = 1'($urandom_range(0, 1));
        #1;
        chk1("idle_m_select", m_select, 1'b0);
        chk1("idle_busy", busy, 1'b0);
        no_response("idle");
        for (int k = 1; k <= done_k; k++) begin
            tick();
            if (k == abort_at) begin
                if (win) h_select = 1'b0;
                else     c_select = 1'b0;
            end
            m_data_ready = (k == lat);
            m_data_out   = (k == lat) ? rdata : 8'($urandom);
            #1;
            chk1("busy_m_select", m_select, 1'b1);
            chk1("busy_flag", busy, 1'b1);
            chk1("busy_grant", grant, win);
            chk8("busy_m_addr", m_addr, win ? h_addr : c_addr);
            chk8("busy_m_data_in", m_data_in, win ? h_data_in : c_data_in);
            chk8("busy_m_type", {6'd0, m_type}, {6'd0, (win ? h_type : c_type)});
            chk1("busy_m_write", m_write, win ? h_write : c_write);
            if (k == abort_at) begin
                aborted = 1'b1;
                no_response("abort");
                break;
            end else if (k == done_k) begin
                chk1("done_c_ready", c_data_ready, !win);
                chk1("done_h_ready", h_data_ready, win);
                chk1("done_c_error", c_error, !win && is_to);
                chk1("done_h_error", h_error, win && is_to);
            end else begin
                no_response("wait");
            end
        end
        model_last = win;
        if (!aborted && !is_to) begin
            if (win) exp_h_out = rdata;
            else     exp_c_out = rdata;
        end
        tick();
        m_data_ready = 1'($urandom_range(0, 1));
        #1;
        chk1("rel_m_select", m_select, 1'b0);
        chk1("rel_busy", busy, 1'b1);
        no_response("rel");
        chk8("rel_c_out", c_data_out, exp_c_out);
        chk8("rel_h_out", h_data_out, exp_h_out);
        c_select = c_select & keep_c;
        h_select = h_select & keep_h;
        m_data_ready = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        {c_select, c_write, h_select, h_write, m_data_ready} = '0;
        {c_addr, c_data_in, h_addr, h_data_in, m_data_out} = '0;
        c_type = MemoryTypeData;
        h_type = MemoryTypeData;
        do_reset();

        // core read of code byte, memory answers in the third Busy cycle
        c_addr = 8'h10; c_type = MemoryTypeCode; c_write = 1'b0; c_data_in = 8'h00;
        run_txn(1, 0, 3, 0, 8'hA5, 0, 0);

        // simultaneous requests after reset: core first, then host write
        do_reset();
        c_addr = 8'h33; c_type = MemoryTypeCode; c_write = 1'b0;
        h_addr = 8'h20; h_data_in = 8'h5A; h_type = MemoryTypeData; h_write = 1'b1;
        run_txn(1, 1, 2, 0, 8'h11, 0, 1);
        run_txn(0, 1, 4, 0, 8'h77, 0, 0);

        // memory never answers: timeout completion
        c_addr = 8'h44; c_write = 1'b0;
        run_txn(1, 0, 99, 0, 8'h00, 0, 0);

        // host abandons its access mid-Busy
        h_addr = 8'h55; h_write = 1'b0;
        run_txn(0, 1, 6, 2, 8'hEE, 0, 0);

        // core holds its request; the waiting host is served in between
        run_txn(1, 1, 1, 0, 8'h21, 1, 1);
        run_txn(1, 1, 2, 0, 8'h42, 1, 0);
        run_txn(1, 0, 3, 0, 8'h63, 0, 0);

        // reset while an access is in flight
        c_select = 1'b1;
        tick();
        chk1("mid_m_select", m_select, 1'b1);
        tick();
        do_reset();

        for (int n = 0; n < 40; n++) begin
            int r, lat, ab, dk;
            r   = int'($urandom_range(1, 3));
            lat = int'($urandom_range(1, 7));
            dk  = (lat < TO + 1) ? lat : TO + 1;
            ab  = 0;
            if ($urandom_range(0, 5) == 0 && dk > 1) ab = int'($urandom_range(1, dk - 1));
            c_addr = 8'($urandom); c_data_in = 8'($urandom); c_type = 2'($urandom); c_write = 1'($urandom);
            h_addr = 8'($urandom); h_data_in = 8'($urandom); h_type = 2'($urandom); h_write = 1'($urandom);
            run_txn(r[0], r[1], lat, ab, 8'($urandom), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
